// File: rtl/ddr_cmd_executor_if.sv
// Arbiter-side command bus of the DDR command executor.
//   cmd / cmd_valid / ddr_address / ddr_wr_data : command strobe and payload from the arbiter
//   cmd_busy                                    : executor cannot accept a command this cycle
//   ddr_rd_data / ddr_rd_valid                  : single-cycle read return
// master = arbiter side, slave = executor side.
interface ddr_cmd_executor_if;
  logic [3:0]   cmd;
  logic         cmd_valid;
  logic [24:0]  ddr_address;
  logic [127:0] ddr_wr_data;
  logic         cmd_busy;
  logic [127:0] ddr_rd_data;
  logic         ddr_rd_valid;

  modport master (
    output cmd, cmd_valid, ddr_address, ddr_wr_data,
    input  cmd_busy, ddr_rd_data, ddr_rd_valid
  );

  modport slave (
    input  cmd, cmd_valid, ddr_address, ddr_wr_data,
    output cmd_busy, ddr_rd_data, ddr_rd_valid
  );
endinterface

// File: rtl/ddr_cmd_executor.sv
// Memory-side endpoint of the arbiter command bus. Runs controller init,
// then executes one read or write at a time on the DDR controller IP
// local interface and returns read data as a one-cycle pulse.
// Ports:
//   clk_133M, rst_133M        : clock, synchronous active-high reset
//   host (slave modport)      : arbiter command bus (cmd, cmd_valid, ddr_address,
//                               ddr_wr_data, cmd_busy, ddr_rd_data, ddr_rd_valid)
//   init_done                 : memory initialised (level)
//   rd_timeout_err, proto_err : sticky error flags
//   mem_init_start/done       : init handshake with controller IP
//   mem_cmd*, mem_addr        : command request to IP
//   mem_wr_data/datain_rdy    : write data to IP
//   mem_rd_data/_valid        : read data from IP
module ddr_cmd_executor #(
  parameter logic [3:0]  CMD_READ   = 4'b0011,
  parameter logic [3:0]  CMD_WRITE  = 4'b0100,
  parameter int unsigned INIT_DELAY = 16,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                clk_133M,
  input  logic                rst_133M,
  ddr_cmd_executor_if.slave   host,
  output logic                init_done,
  output logic                rd_timeout_err,
  output logic                proto_err,
  output logic                mem_init_start,
  input  logic                mem_init_done,
  output logic [3:0]          mem_cmd,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_rdy,
  output logic [24:0]         mem_addr,
  output logic [127:0]        mem_wr_data,
  input  logic                mem_datain_rdy,
  input  logic [127:0]        mem_rd_data,
  input  logic                mem_rd_data_valid
);

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WDATA,
    ST_RD_WAIT
  } state_t;

  localparam logic [7:0] INIT_LAST = 8'(INIT_DELAY - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         rd_valid_q, rd_valid_d;
  logic [127:0] rd_data_q, rd_data_d;
  logic         init_done_d, init_start_d, rto_d, perr_d, mcv_d;
  logic [3:0]   mcmd_d;
  logic [24:0]  maddr_d;
  logic [127:0] mwd_d;
  logic         cmd_known;

  assign cmd_known         = (host.cmd == CMD_READ) || (host.cmd == CMD_WRITE);
  assign host.cmd_busy     = busy_q;
  assign host.ddr_rd_valid = rd_valid_q;
  assign host.ddr_rd_data  = rd_data_q;

  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      state_q        <= ST_INIT_WAIT;
      cnt_q          <= '0;
      busy_q         <= 1'b1;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      init_done      <= 1'b0;
      mem_init_start <= 1'b0;
      rd_timeout_err <= 1'b0;
      proto_err      <= 1'b0;
      mem_cmd_valid  <= 1'b0;
      mem_cmd        <= '0;
      mem_addr       <= '0;
      mem_wr_data    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      init_done      <= init_done_d;
      mem_init_start <= init_start_d;
      rd_timeout_err <= rto_d;
      proto_err      <= perr_d;
      mem_cmd_valid  <= mcv_d;
      mem_cmd        <= mcmd_d;
      mem_addr       <= maddr_d;
      mem_wr_data    <= mwd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    init_done_d  = init_done;
    init_start_d = mem_init_start;
    rto_d        = rd_timeout_err;
    perr_d       = proto_err;
    mcv_d        = mem_cmd_valid;
    mcmd_d       = mem_cmd;
    maddr_d      = mem_addr;
    mwd_d        = mem_wr_data;

    if (host.cmd_valid && ((state_q != ST_IDLE) || !cmd_known)) perr_d = 1'b1;

    unique case (state_q)
      ST_INIT_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d        = '0;
          init_start_d = 1'b1;
          state_d      = ST_INIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_INIT: begin
        if (mem_init_done) begin
          init_start_d = 1'b0;
          init_done_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // mem_cmd/mem_addr/mem_wr_data double as the command latches.
        if (host.cmd_valid && cmd_known) begin
          mcmd_d  = host.cmd;
          maddr_d = host.ddr_address;
          if (host.cmd == CMD_WRITE) mwd_d = host.ddr_wr_data;
          mcv_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_cmd_rdy) begin
          mcv_d   = 1'b0;
          cnt_d   = '0;
          state_d = (mem_cmd == CMD_WRITE) ? ST_WDATA : ST_RD_WAIT;
        end
      end
      ST_WDATA: begin
        if (mem_datain_rdy) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        // Data arriving on the final counted cycle still wins over timeout.
        if (mem_rd_data_valid) begin
          rd_data_d  = mem_rd_data;
          rd_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == RD_LAST) begin
          rto_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_INIT_WAIT;
    endcase

    // Busy is registered from the next state so it is low exactly while in IDLE.
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: doc/ddr_cmd_executor.md
Name: ddr_cmd_executor

Overview:
- Memory-side endpoint of the 4-bit cmd / cmd_valid / cmd_busy command interface issued by the DDR request arbiter.
- Accepts one read or write command at a time and sequences it onto the DDR controller IP local interface (cmd/ready, write-data ready, read-data valid).
- Returns read data as a single-cycle ddr_rd_valid pulse.
- Owns controller initialisation and holds cmd_busy high until memory is ready.

Parameters:
- CMD_READ, 4'b0011, command code for a 128-bit single-beat read
- CMD_WRITE, 4'b0100, command code for a 128-bit single-beat write
- INIT_DELAY, 16, cycles to wait after reset before pulsing mem_init_start
- RD_TIMEOUT, 255, max cycles in RD_WAIT before abort (8-bit counter)

Ports:
- clk_133M  in  1  system clock, all logic on rising edge
- rst_133M  in  1  synchronous active-high reset
- cmd  in  4  command code, sampled when cmd_valid=1
- cmd_valid  in  1  single-cycle command strobe from arbiter
- ddr_address  in  25  command address
- ddr_wr_data  in  128  write payload
- cmd_busy  out  1  high = command not accepted this cycle
- ddr_rd_data  out  128  read payload, valid with ddr_rd_valid
- ddr_rd_valid  out  1  one-cycle read-return pulse
- init_done  out  1  memory initialised, level
- rd_timeout_err  out  1  sticky: a read was aborted
- proto_err  out  1  sticky: cmd_valid while busy, or unknown cmd code
- mem_init_start  out  1  init request to controller IP
- mem_init_done  in  1  init complete from controller IP
- mem_cmd  out  4  command to IP
- mem_cmd_valid  out  1  command request to IP
- mem_cmd_rdy  in  1  IP accepts command when high with mem_cmd_valid
- mem_addr  out  25  address to IP
- mem_wr_data  out  128  write data to IP
- mem_datain_rdy  in  1  IP consumes mem_wr_data this cycle
- mem_rd_data  in  128  read data from IP
- mem_rd_data_valid  in  1  read data valid from IP

Behaviour:
- Reset values (held while rst_133M=1): state=INIT_WAIT, cmd_busy=1, init_done=0, ddr_rd_valid=0, ddr_rd_data=0, mem_init_start=0, mem_cmd_valid=0, mem_cmd=0, mem_addr=0, mem_wr_data=0, both error flags=0, counters=0. All outputs are registered.
- Reset mid-operation aborts any command. No ddr_rd_valid is emitted afterwards, including a late mem_rd_data_valid.
- INIT_WAIT: count INIT_DELAY cycles, then go to INIT.
- INIT: mem_init_start=1 until mem_init_done is sampled high. Then mem_init_start=0, init_done=1 (stays 1 until reset), go to IDLE.
- IDLE: cmd_busy=0 in this state only; it is 1 in every other state.
- IDLE, cmd_valid=1, cmd=CMD_READ or CMD_WRITE: latch cmd, ddr_address, ddr_wr_data. Next cycle: cmd_busy=1, mem_cmd_valid=1, mem_cmd/mem_addr driven from latches. Go to ISSUE.
- IDLE, cmd_valid=1, unknown code: drop the command, set proto_err, stay in IDLE, cmd_busy stays 0.
- cmd_valid=1 in any state other than IDLE: command ignored, proto_err set.
- ISSUE: hold mem_cmd_valid until an edge with mem_cmd_rdy=1. At that edge mem_cmd_valid drops; write goes to WDATA, read goes to RD_WAIT. No timeout in ISSUE.
- WDATA: mem_wr_data holds the latched payload. At the edge with mem_datain_rdy=1, go to IDLE; cmd_busy=0 the next cycle.
- Write minimum latency: cmd_valid edge to cmd_busy low = 3 cycles when rdy signals are already high.
- RD_WAIT: 8-bit counter increments each cycle.
- RD_WAIT, edge with mem_rd_data_valid=1: ddr_rd_data<=mem_rd_data and ddr_rd_valid=1 for exactly one cycle. cmd_busy falls in that same cycle; go to IDLE.
- RD_WAIT, counter reaches RD_TIMEOUT with no data: set rd_timeout_err, no ddr_rd_valid, go to IDLE.
- mem_rd_data_valid outside RD_WAIT: ignored.
- ddr_rd_data holds its last value between pulses.
- Simultaneous events on the same edge: data valid wins over timeout, and only the data path is taken.
- Exactly one command is outstanding at any time; there is no queueing.

Test Plan:
- Reset, then mem_init_done rises 5 cycles after mem_init_start -> mem_init_start high from cycle 17; init_done=1 and cmd_busy=0 one cycle after mem_init_done; cmd_busy=1 throughout before that.
- Write cmd=0100, addr=25'h0000ABC, data=128'hDEAD..BEEF, mem_cmd_rdy held 1, mem_datain_rdy asserted after 2 cycles -> mem_cmd=0100 and mem_addr=0xABC for one cycle, mem_wr_data=payload, cmd_busy back to 0 one cycle after datain_rdy.
- Read cmd=0011, addr=25'h1FFFFFF, mem_rd_data_valid 7 cycles after command acceptance with data 128'h0123..CDEF -> ddr_rd_data equals it, ddr_rd_valid high exactly 1 cycle, cmd_busy low the same cycle.
- Read with no mem_rd_data_valid -> after 255 cycles in RD_WAIT rd_timeout_err=1, no ddr_rd_valid; a later stray mem_rd_data_valid is ignored.
- cmd=0111 in IDLE, then cmd_valid during WDATA -> proto_err=1, neither command reaches mem_cmd_valid, and the in-flight write completes normally.
- Reset asserted during RD_WAIT, followed by mem_rd_data_valid -> all outputs at reset values; ddr_rd_valid stays 0.
